// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path: FSM encoding,
// parity selectors, supported oversampling ratios and small helpers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

endpackage

// File: rtl/uart_rx_data_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// The oversampling ratio is captured when a frame starts.
module uart_rx_data_sampler
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       active,
  input  logic       ser_data_in,
  input  logic [5:0] prescale,
  output logic       sampled_bit,
  output logic       bit_done,
  output logic       sample_done
);

  logic [5:0] p_q;
  logic [5:0] edge_cnt_q;
  logic [5:0] edge_cnt_d;
  logic [5:0] half;
  logic [2:0] samples_q;

  assign half = {1'b0, p_q[5:1]};

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (start) begin
      edge_cnt_d = 6'd1;
    end else if (!active) begin
      edge_cnt_d = 6'd0;
    end else if (edge_cnt_q == p_q - 6'd1) begin
      edge_cnt_d = 6'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_cnt_q <= 6'd0;
      p_q        <= PRESCALE_8;
      samples_q  <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      // An unsupported ratio falls back to 16 so the counter always wraps.
      if (start) begin
        p_q <= is_legal_prescale(prescale) ? prescale : PRESCALE_16;
      end
      if (active) begin
        if (edge_cnt_q == half - 6'd1) samples_q[0] <= ser_data_in;
        if (edge_cnt_q == half)        samples_q[1] <= ser_data_in;
        if (edge_cnt_q == half + 6'd1) samples_q[2] <= ser_data_in;
      end
    end
  end

  assign sampled_bit = majority3(samples_q);
  assign bit_done    = active && (edge_cnt_q == p_q - 6'd1);
  assign sample_done = active && (edge_cnt_q == half + 6'd2);

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: frame FSM, LSB-first shift register, parity/stop
// checking and one-cycle result pulses towards the processor side.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ser_data_in,
  input  logic [5:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_type,
  output logic [DATA_WIDTH-1:0] parallel_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stop_err
);

  localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  mismatch_q, mismatch_d;
  logic [DATA_WIDTH-1:0] parallel_data_q, parallel_data_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stop_err_q, stop_err_d;

  logic start;
  logic active;
  logic sampled_bit;
  logic bit_done;
  logic sample_done;
  logic exp_par;

  assign start  = (state_q == ST_IDLE) && !ser_data_in;
  assign active = (state_q != ST_IDLE);

  uart_rx_data_sampler u_sampler (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .active      (active),
    .ser_data_in (ser_data_in),
    .prescale    (prescale),
    .sampled_bit (sampled_bit),
    .bit_done    (bit_done),
    .sample_done (sample_done)
  );

  always_comb begin
    exp_par = ^data_q;
    case (par_type)
      PAR_EVEN: exp_par = ^data_q;
      PAR_ODD:  exp_par = ~^data_q;
      default:  exp_par = ^data_q;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    bit_cnt_d       = bit_cnt_q;
    data_d          = data_q;
    mismatch_d      = mismatch_q;
    parallel_data_d = parallel_data_q;
    data_valid_d    = 1'b0;
    par_err_d       = 1'b0;
    stop_err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!ser_data_in) begin
          state_d    = ST_START;
          bit_cnt_d  = '0;
          mismatch_d = 1'b0;
        end
      end
      ST_START: begin
        // A start bit that votes high was a line glitch.
        if (bit_done) begin
          state_d = sampled_bit ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          data_d[bit_cnt_q] = sampled_bit;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = par_en ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          mismatch_d = (sampled_bit != exp_par);
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        // Leave at the vote so the tail of the stop bit can resync as idle.
        if (sample_done) begin
          state_d    = ST_IDLE;
          stop_err_d = ~sampled_bit;
          par_err_d  = par_en & mismatch_q;
          if (sampled_bit && !(par_en && mismatch_q)) begin
            parallel_data_d = data_q;
            data_valid_d    = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      bit_cnt_q       <= '0;
      data_q          <= '0;
      mismatch_q      <= 1'b0;
      parallel_data_q <= '0;
      data_valid_q    <= 1'b0;
      par_err_q       <= 1'b0;
      stop_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      bit_cnt_q       <= bit_cnt_d;
      data_q          <= data_d;
      mismatch_q      <= mismatch_d;
      parallel_data_q <= parallel_data_d;
      data_valid_q    <= data_valid_d;
      par_err_q       <= par_err_d;
      stop_err_q      <= stop_err_d;
    end
  end

  assign parallel_data = parallel_data_q;
  assign data_valid    = data_valid_q;
  assign par_err       = par_err_q;
  assign stop_err      = stop_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: frames are driven serially, the
// expected pulse (kind, data, absolute cycle) is queued and matched later.
module tb_uart_receiver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ser_data_in;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_type;
  logic [7:0] parallel_data;
  logic       data_valid;
  logic       par_err;
  logic       stop_err;

  typedef struct packed {
    logic        dv;
    logic        pe;
    logic        se;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        obs_q[$];
  logic [31:0] cyc = 0;
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         passes = 0;

  uart_receiver #(.DATA_WIDTH(8)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ser_data_in   (ser_data_in),
    .prescale      (prescale),
    .par_en        (par_en),
    .par_type      (par_type),
    .parallel_data (parallel_data),
    .data_valid    (data_valid),
    .par_err       (par_err),
    .stop_err      (stop_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && (data_valid || par_err || stop_err)) begin
      obs_q.push_back('{data_valid, par_err, stop_err, parallel_data, cyc});
      $display("pulse cyc=%0d dv=%0b pe=%0b se=%0b data=%02h", cyc, data_valid, par_err, stop_err, parallel_data);
    end
  end

  task automatic idle(input int n);
    ser_data_in = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v, input int p);
    ser_data_in = v;
    repeat (p) @(posedge clk);
    #1;
  endtask

  // Drives one frame starting now (called just after a rising edge) and
  // queues the pulse the receiver must produce for it.
  task automatic send_frame(input logic [7:0] d, input int p, input logic pen,
                            input logic ptype, input logic pbit, input logic stopb);
    logic  exp_p, pe, se, dv;
    logic [31:0] t0;
    prescale = 6'(p);
    par_en   = pen;
    par_type = ptype;
    t0 = cyc;
    exp_p = ptype ? ~^d : ^d;
    pe = pen && (pbit != exp_p);
    se = !stopb;
    dv = !pe && !se;
    if (dv) last_good = d;
    exp_q.push_back('{dv, pe, se, last_good, t0 + 32'((9 + int'(pen)) * p + p / 2 + 3)});
    $display("send d=%02h P=%0d par_en=%0b par_type=%0b pbit=%0b stop=%0b t0=%0d", d, p, pen, ptype, pbit, stopb, t0);
    drive_bit(1'b0, p);
    for (int i = 0; i < 8; i++) drive_bit(d[i], p);
    if (pen) drive_bit(pbit, p);
    drive_bit(stopb, p);
    ser_data_in = 1'b1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ser_data_in = 1'b1;
    prescale = 6'd8;
    par_en = 1'b0;
    par_type = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({parallel_data, data_valid, par_err, stop_err} !== 11'd0)
      $display("FAIL reset_outputs: got data=%02h dv=%0b pe=%0b se=%0b, expected all 0", parallel_data, data_valid, par_err, stop_err);
    else passes++;
    reset_n = 1'b1;
    idle(20);
    checks++;
    if (obs_q.size() != 0) $display("FAIL reset_idle_quiet: got %0d pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_basic;
    ev_t e, o;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL basic_event: got no pulse, expected dv=%0b data=%02h cyc=%0d", e.dv, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL basic_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL basic_extra: got %0d extra pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_parity;
    ev_t e, o;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(32);
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1);
    idle(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL parity_event: got no pulse, expected dv=%0b pe=%0b data=%02h cyc=%0d", e.dv, e.pe, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL parity_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL parity_extra: got %0d extra pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_stop_err;
    ev_t e, o;
    send_frame(8'h01, 8, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(16);
    send_frame(8'h00, 8, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL stop_event: got no pulse, expected dv=%0b se=%0b data=%02h cyc=%0d", e.dv, e.se, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL stop_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL stop_extra: got %0d extra pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_glitch;
    ev_t e, o;
    prescale = 6'd16;
    par_en = 1'b0;
    ser_data_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    idle(40);
    checks++;
    if (obs_q.size() != 0) $display("FAIL glitch_quiet: got %0d pulses, expected 0", obs_q.size());
    else passes++;
    send_frame(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL glitch_event: got no pulse, expected dv=%0b data=%02h cyc=%0d", e.dv, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL glitch_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL glitch_extra: got %0d extra pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  task automatic test_back_to_back;
    ev_t e, o;
    logic [31:0] first_cyc;
    first_cyc = 0;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(16);
    checks++;
    if (obs_q.size() != 2) $display("FAIL b2b_count: got %0d pulses, expected 2", obs_q.size());
    else begin
      if (obs_q[1].cyc - obs_q[0].cyc !== 32'd80)
        $display("FAIL b2b_spacing: got %0d cycles, expected 80", obs_q[1].cyc - obs_q[0].cyc);
      else passes++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL b2b_event: got no pulse, expected dv=%0b data=%02h cyc=%0d", e.dv, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL b2b_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    obs_q.delete();
  endtask

  task automatic test_reset_mid_frame;
    ev_t e, o;
    logic [7:0] d;
    d = 8'hC3;
    prescale = 6'd8;
    par_en = 1'b0;
    drive_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) drive_bit(d[i], 8);
    ser_data_in = d[4];
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    last_good = 8'h00;
    checks++;
    if ({parallel_data, data_valid, par_err, stop_err} !== 11'd0)
      $display("FAIL midreset_outputs: got data=%02h dv=%0b pe=%0b se=%0b, expected all 0", parallel_data, data_valid, par_err, stop_err);
    else passes++;
    ser_data_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(80);
    checks++;
    if (obs_q.size() != 0) $display("FAIL midreset_quiet: got %0d pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) $display("FAIL midreset_event: got no pulse, expected dv=%0b data=%02h cyc=%0d", e.dv, e.data, e.cyc);
      else begin
        o = obs_q.pop_front();
        if (o !== e) $display("FAIL midreset_event: got dv=%0b pe=%0b se=%0b data=%02h cyc=%0d, expected dv=%0b pe=%0b se=%0b data=%02h cyc=%0d", o.dv, o.pe, o.se, o.data, o.cyc, e.dv, e.pe, e.se, e.data, e.cyc);
        else passes++;
      end
    end
    checks++;
    if (obs_q.size() != 0) $display("FAIL midreset_extra: got %0d extra pulses, expected 0", obs_q.size());
    else passes++;
    obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_stop_err();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receive stage, directly downstream of the UART transmitter; consumes its serial line (idle high, start 0, LSB-first data, optional parity, one stop 1).
- clk is an oversampling clock: each bit lasts `prescale` clk cycles.
- Majority-votes each bit, checks parity and stop, and delivers one byte per frame with a one-cycle valid pulse to the processor-side logic.

Parameters:
- DATA_WIDTH, 8, data bits per frame.

Ports:
- clk  input  1  clock (oversampling clock).
- reset_n  input  1  asynchronous reset, active low.
- ser_data_in  input  1  serial line; idle high.
- prescale  input  6  clk cycles per bit; legal values 8, 16, 32.
- par_en  input  1  1 = frame carries a parity bit.
- par_type  input  1  0 = even parity, 1 = odd parity.
- parallel_data  output  DATA_WIDTH  last good received word; held until next good frame.
- data_valid  output  1  one-cycle pulse: parallel_data updated, frame error-free.
- par_err  output  1  one-cycle pulse: parity mismatch on the finished frame.
- stop_err  output  1  one-cycle pulse: stop bit sampled 0.

Behaviour:
- Reset (async, reset_n=0): state IDLE; counters 0; parallel_data=0, data_valid=0, par_err=0, stop_err=0. Reset mid-frame discards the frame; no pulses are produced.
- Counters:
  - edge_cnt counts 0..P-1 within a bit.
  - bit_cnt counts data bits 0..DATA_WIDTH-1.
  - P = prescale, latched on start detection; prescale changes mid-frame are ignored. Illegal P gives undefined results.
- Sampling:
  - ser_data_in is sampled at edge_cnt = P/2-1, P/2 and P/2+1.
  - The bit value is the majority of the three samples, decided at edge_cnt = P/2+2.
- States:
  - IDLE: the first cycle with ser_data_in=0 is edge 0 of the start bit. Latch P; go to START with edge_cnt=1.
  - START: at edge_cnt=P-1, if the voted bit is 1 (glitch), go to IDLE with no outputs. Otherwise go to DATA with bit_cnt=0.
  - DATA: at edge_cnt=P-1, store the voted bit at index bit_cnt (LSB first). After bit DATA_WIDTH-1, go to PARITY if par_en, else STOP.
  - PARITY: expected bit = ^data when par_type=0; ~^data when par_type=1. Record a mismatch flag. At edge_cnt=P-1, go to STOP.
  - STOP: at the decision point edge_cnt=P/2+2, end the frame and go to IDLE. The rest of the stop bit is treated as idle, which resynchronises on the next falling edge. This allows back-to-back frames.
- Frame end (registered outputs, visible in the cycle after the decision):
  - stop_err = (voted stop bit == 0).
  - par_err = par_en & mismatch.
  - If neither error: parallel_data <= received word and data_valid=1. Otherwise parallel_data is unchanged.
  - All pulses deassert the following cycle.
- Latency: with cycle 0 = first low cycle of the start bit and N = 1 + DATA_WIDTH + par_en, the pulses are high in cycle N*P + P/2 + 3.
- par_en and par_type are sampled as seen at the parity/stop decisions; they must be stable for the whole frame.

Decomposition:
- Shared package uart_pkg:
  - receiver state encoding (IDLE, START, DATA, PARITY, STOP);
  - PAR_EVEN=1'b0 and PAR_ODD=1'b1;
  - legal prescale constants 8, 16, 32.
- Sub-module uart_rx_data_sampler: edge counter plus 3-sample majority vote. Outputs sampled_bit, bit_done (edge_cnt=P-1) and sample_done (edge_cnt=P/2+2).
- The FSM, shift register, parity check and output registers stay in uart_receiver.

Test Plan:
- P=8, par_en=0, send 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> data_valid pulse in cycle 79, parallel_data=0xA5, par_err=0, stop_err=0.
- P=16, par_en=1, par_type=0, send 0x3C with parity 0 -> data_valid in cycle 171, data 0x3C. Repeat with parity 1 -> par_err pulse in cycle 171, no data_valid, parallel_data still 0x3C.
- P=8, par_en=1, par_type=1, send 0x01 with parity 0 -> data_valid, data 0x01. Then send 0x00 with stop bit forced 0 -> stop_err pulse, data_valid=0, parallel_data still 0x01.
- Start glitch: P=16, line low for 4 cycles then high -> returns to IDLE, no pulses. A following clean frame 0x5A is received correctly.
- Back-to-back frames: P=8, transmitter sends 0x12 then 0x34 with one stop bit each -> two data_valid pulses exactly 80 cycles apart, data 0x12 then 0x34.
- Reset mid-frame: assert reset_n=0 during DATA bit 4 -> all outputs 0 immediately. After release, a fresh frame 0xFF gives data_valid with data 0xFF.
